// File: rtl/clink_pkg.sv
// Shared definitions for the Camera Link Base 3-tap 8-bit frame source.
// State codes, tap geometry and serializer bit positions.
`timescale 1ns/1ps
package clink_pkg;

  localparam int TAP_W = 8;
  localparam int TAP_N = 3;

  typedef logic [TAP_W-1:0] tap_t;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LEAD   = 3'd1;
  localparam state_t S_ACTIVE = 3'd2;
  localparam state_t S_HBLANK = 3'd3;
  localparam state_t S_VBLANK = 3'd4;

  localparam int PX_D1_0  = 0;
  localparam int PX_D0_5  = 1;
  localparam int PX_D0_4  = 2;
  localparam int PX_D0_3  = 3;
  localparam int PX_D0_2  = 4;
  localparam int PX_D0_1  = 5;
  localparam int PX_D0_0  = 6;
  localparam int PX_D2_1  = 7;
  localparam int PX_D2_0  = 8;
  localparam int PX_D1_5  = 9;
  localparam int PX_D1_4  = 10;
  localparam int PX_D1_3  = 11;
  localparam int PX_D1_2  = 12;
  localparam int PX_D1_1  = 13;
  localparam int PX_DVAL  = 14;
  localparam int PX_FVAL  = 15;
  localparam int PX_LVAL  = 16;
  localparam int PX_D2_5  = 17;
  localparam int PX_D2_4  = 18;
  localparam int PX_D2_3  = 19;
  localparam int PX_D2_2  = 20;
  localparam int PX_SPARE = 21;
  localparam int PX_D2_7  = 22;
  localparam int PX_D2_6  = 23;
  localparam int PX_D1_7  = 24;
  localparam int PX_D1_6  = 25;
  localparam int PX_D0_7  = 26;
  localparam int PX_D0_6  = 27;

  // Tap A value for column c, row r: (3c + r) mod 256
  function automatic tap_t ramp(input tap_t c, input tap_t r);
    return tap_t'(c + c + c + r);
  endfunction

endpackage

// File: rtl/clink_tx_mapper.sv
// Combinational packer of taps and valids into the 28-bit 7:1 word.
// Exact inverse of the X-channel receive bit mapping.
`timescale 1ns/1ps
module clink_tx_mapper
  import clink_pkg::*;
(
  input  logic [7:0]  d0,
  input  logic [7:0]  d1,
  input  logic [7:0]  d2,
  input  logic        lval,
  input  logic        fval,
  input  logic        dval,
  output logic [27:0] px
);

  always_comb begin
    px = '0;
    px[PX_D1_0]  = d1[0];
    px[PX_D0_5]  = d0[5];
    px[PX_D0_4]  = d0[4];
    px[PX_D0_3]  = d0[3];
    px[PX_D0_2]  = d0[2];
    px[PX_D0_1]  = d0[1];
    px[PX_D0_0]  = d0[0];
    px[PX_D2_1]  = d2[1];
    px[PX_D2_0]  = d2[0];
    px[PX_D1_5]  = d1[5];
    px[PX_D1_4]  = d1[4];
    px[PX_D1_3]  = d1[3];
    px[PX_D1_2]  = d1[2];
    px[PX_D1_1]  = d1[1];
    px[PX_DVAL]  = dval;
    px[PX_FVAL]  = fval;
    px[PX_LVAL]  = lval;
    px[PX_D2_5]  = d2[5];
    px[PX_D2_4]  = d2[4];
    px[PX_D2_3]  = d2[3];
    px[PX_D2_2]  = d2[2];
    px[PX_SPARE] = 1'b0;
    px[PX_D2_7]  = d2[7];
    px[PX_D2_6]  = d2[6];
    px[PX_D1_7]  = d1[7];
    px[PX_D1_6]  = d1[6];
    px[PX_D0_7]  = d0[7];
    px[PX_D0_6]  = d0[6];
  end

endmodule

// File: rtl/clink_frame_generator.sv
// Camera Link Base 3-tap frame source: FVAL/LVAL/DVAL timing + pixel ramp.
// Optional CLINK_TX_FRAME_CNT_EN stamps a frame counter on row 0 col 0.
`timescale 1ns/1ps
module clink_frame_generator
  import clink_pkg::*;
#(
  parameter int WIDTH_BITS  = 12,
  parameter int HEIGHT_BITS = 12,
  parameter int BLANK_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [WIDTH_BITS-1:0]  line_taps,
  input  logic [HEIGHT_BITS-1:0] lines,
  input  logic [BLANK_BITS-1:0]  h_blank,
  input  logic [BLANK_BITS-1:0]  v_blank,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             d0,
  output logic [7:0]             d1,
  output logic [7:0]             d2,
  output logic                   lval,
  output logic                   fval,
  output logic                   dval,
  output logic [27:0]            px_data
);

  state_t state, nstate;
  logic [WIDTH_BITS-1:0]  col, ncol, c_taps;
  logic [HEIGHT_BITS-1:0] row, nrow, c_lines;
  logic [BLANK_BITS-1:0]  bcnt, nbcnt, c_hb, c_vb;
  logic [BLANK_BITS-1:0]  hb_last, vb_last;
  logic [WIDTH_BITS-1:0]  taps_last;
  logic [HEIGHT_BITS-1:0] lines_last;
  logic accept;
  logic n_act, n_fval, n_busy, n_done;
  tap_t nd0, nd1, nd2, base;
  logic [27:0] px_next;

  assign accept = (state == S_IDLE) && start &&
                  (line_taps != '0) && (lines != '0);

  // Zero blanking lengths behave as a single cycle
  assign hb_last = (c_hb == '0) ? '0 : c_hb - BLANK_BITS'(1);
  assign vb_last = (c_vb == '0) ? '0 : c_vb - BLANK_BITS'(1);
  assign taps_last  = c_taps - WIDTH_BITS'(1);
  assign lines_last = c_lines - HEIGHT_BITS'(1);

  always_comb begin
    nstate = state;
    ncol   = col;
    nrow   = row;
    nbcnt  = bcnt;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          nstate = S_LEAD;
          ncol   = '0;
          nrow   = '0;
          nbcnt  = '0;
        end
      end
      S_LEAD: begin
        if (bcnt == hb_last) begin
          nstate = S_ACTIVE;
          nbcnt  = '0;
        end else begin
          nbcnt = bcnt + BLANK_BITS'(1);
        end
      end
      S_ACTIVE: begin
        if (col == taps_last) nstate = S_HBLANK;
        else ncol = col + WIDTH_BITS'(1);
      end
      S_HBLANK: begin
        if (bcnt == hb_last) begin
          nbcnt = '0;
          if (row == lines_last) begin
            nstate = S_VBLANK;
          end else begin
            nstate = S_ACTIVE;
            nrow   = row + HEIGHT_BITS'(1);
            ncol   = '0;
          end
        end else begin
          nbcnt = bcnt + BLANK_BITS'(1);
        end
      end
      S_VBLANK: begin
        if (bcnt == vb_last) begin
          nbcnt  = '0;
          nrow   = '0;
          ncol   = '0;
          nstate = continuous ? S_LEAD : S_IDLE;
        end else begin
          nbcnt = bcnt + BLANK_BITS'(1);
        end
      end
      default: begin
        nstate = S_IDLE;
        ncol   = '0;
        nrow   = '0;
        nbcnt  = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with state
  assign n_act  = (nstate == S_ACTIVE);
  assign n_fval = (nstate == S_LEAD) || n_act || (nstate == S_HBLANK);
  assign n_busy = (nstate != S_IDLE);
  assign n_done = (nstate == S_VBLANK) && (state != S_VBLANK);
  assign base   = ramp(TAP_W'(ncol), TAP_W'(nrow));

`ifdef CLINK_TX_FRAME_CNT_EN
  logic [15:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt <= '0;
    else if (n_done) fcnt <= fcnt + 16'd1;
  end

  always_comb begin
    nd0 = '0;
    nd1 = '0;
    nd2 = '0;
    if (n_act && ncol == '0 && nrow == '0) begin
      nd0 = fcnt[7:0];
      nd1 = fcnt[15:8];
      nd2 = 8'hA5;
    end else if (n_act) begin
      nd0 = base;
      nd1 = base + 8'd1;
      nd2 = base + 8'd2;
    end
  end
`else
  always_comb begin
    nd0 = '0;
    nd1 = '0;
    nd2 = '0;
    if (n_act) begin
      nd0 = base;
      nd1 = base + 8'd1;
      nd2 = base + 8'd2;
    end
  end
`endif

  clink_tx_mapper u_mapper (
    .d0   (nd0),
    .d1   (nd1),
    .d2   (nd2),
    .lval (n_act),
    .fval (n_fval),
    .dval (n_act),
    .px   (px_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      col     <= '0;
      row     <= '0;
      bcnt    <= '0;
      c_taps  <= '0;
      c_lines <= '0;
      c_hb    <= '0;
      c_vb    <= '0;
    end else begin
      state <= nstate;
      col   <= ncol;
      row   <= nrow;
      bcnt  <= nbcnt;
      if (accept) begin
        c_taps  <= line_taps;
        c_lines <= lines;
        c_hb    <= h_blank;
        c_vb    <= v_blank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      d2         <= '0;
      lval       <= 1'b0;
      fval       <= 1'b0;
      dval       <= 1'b0;
      px_data    <= '0;
    end else begin
      busy       <= n_busy;
      frame_done <= n_done;
      d0         <= nd0;
      d1         <= nd1;
      d2         <= nd2;
      lval       <= n_act;
      fval       <= n_fval;
      dval       <= n_act;
      px_data    <= px_next;
    end
  end

endmodule

// File: tb/tb_clink_frame_generator.sv
// Scoreboard bench for clink_frame_generator: pixel queue + frame timing.
// Honours CLINK_TX_FRAME_CNT_EN for the row 0 col 0 stamp.
`timescale 1ns/1ps
module tb_clink_frame_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [11:0] line_taps = '0;
  logic [11:0] lines = '0;
  logic [15:0] h_blank = '0;
  logic [15:0] v_blank = '0;
  logic        busy, frame_done, lval, fval, dval;
  logic [7:0]  d0, d1, d2;
  logic [27:0] px_data;

  always #5 clk = ~clk;

  clink_frame_generator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .line_taps  (line_taps),
    .lines      (lines),
    .h_blank    (h_blank),
    .v_blank    (v_blank),
    .busy       (busy),
    .frame_done (frame_done),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .lval       (lval),
    .fval       (fval),
    .dval       (dval),
    .px_data    (px_data)
  );

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
  } pix_t;

  pix_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          beat_no = 0;
  int          frame_no = 0;
  int          fd_seen = 0;
  int          cyc = 0;
  int          fd_stamp[$];
  logic [27:0] snap_px = '0;
  logic [23:0] snap_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] pack(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic dv,
                                       input logic fv, input logic lv);
    logic [27:0] p;
    p = '0;
    p[0] = b[0];  p[1] = a[5];  p[2] = a[4];  p[3] = a[3];
    p[4] = a[2];  p[5] = a[1];  p[6] = a[0];
    p[7] = c[1];  p[8] = c[0];  p[9] = b[5];  p[10] = b[4];
    p[11] = b[3]; p[12] = b[2]; p[13] = b[1];
    p[14] = dv;   p[15] = fv;   p[16] = lv;   p[17] = c[5];
    p[18] = c[4]; p[19] = c[3]; p[20] = c[2];
    p[22] = c[7]; p[23] = c[6]; p[24] = b[7]; p[25] = b[6];
    p[26] = a[7]; p[27] = a[6];
    return p;
  endfunction

  function automatic logic [56:0] all_out();
    return {busy, frame_done, lval, fval, dval, d0, d1, d2, px_data};
  endfunction

  task automatic push_frame(input int lt, input int nl);
    pix_t p;
    for (int r = 0; r < nl; r++) begin
      for (int c = 0; c < lt; c++) begin
        p.d0 = 8'(3 * c + r);
        p.d1 = p.d0 + 8'd1;
        p.d2 = p.d0 + 8'd2;
`ifdef CLINK_TX_FRAME_CNT_EN
        if (r == 0 && c == 0) begin
          p.d0 = 8'(frame_no);
          p.d1 = 8'(frame_no >> 8);
          p.d2 = 8'hA5;
        end
`endif
        exp_q.push_back(p);
      end
    end
    frame_no++;
  endtask

  // Monitor: every data-valid beat pops one expected pixel triple
  always @(negedge clk) begin
    pix_t p;
    if (rst_n && frame_done) begin
      fd_seen++;
      fd_stamp.push_back(cyc);
    end
    if (rst_n && dval) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        p = exp_q.pop_front();
        check("pixel", {40'd0, d0, d1, d2}, {40'd0, p});
        check("px_data", {36'd0, px_data},
              {36'd0, pack(p.d0, p.d1, p.d2, 1'b1, 1'b1, 1'b1)});
        if (beat_no == 6) begin
          snap_px = px_data;
          snap_d  = {d0, d1, d2};
        end
        beat_no++;
      end
    end
  end

  task automatic do_start(input int lt, input int nl, input int hb,
                          input int vb, input string name);
    line_taps = 12'(lt);
    lines     = 12'(nl);
    h_blank   = 16'(hb);
    v_blank   = 16'(vb);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(name, {62'd0, busy, fval}, 64'd3);
  endtask

  task automatic measure(input int lt, output int fv, output int lvp,
                         output int lvbad, output int fd, output int fdbad,
                         output int tail);
    int run, n;
    logic pl, pf;
    fv = 0; lvp = 0; lvbad = 0; fd = 0; fdbad = 0; tail = 0;
    run = 0; n = 0; pl = 1'b0; pf = 1'b0;
    while (n < 500) begin
      if (fval) fv++;
      if (lval) begin
        run++;
      end else if (pl) begin
        lvp++;
        if (run != lt) lvbad++;
        run = 0;
      end
      if (frame_done) begin
        fd++;
        if (!(pf && !fval)) fdbad++;
      end
      if (busy && !fval) tail++;
      pl = lval;
      pf = fval;
      n++;
      if (!busy) break;
      @(negedge clk);
    end
    check("measure_bound", {63'd0, n < 500}, 64'd1);
  endtask

  task automatic frame_checks(input string tag);
    int fv, lvp, lvbad, fd, fdbad, tail;
    measure(4, fv, lvp, lvbad, fd, fdbad, tail);
    check({tag, "_fval_cycles"}, 64'(fv), 64'd14);
    check({tag, "_lval_pulses"}, 64'(lvp), 64'd2);
    check({tag, "_lval_len"}, 64'(lvbad), 64'd0);
    check({tag, "_frame_done"}, 64'(fd), 64'd1);
    check({tag, "_done_on_fall"}, 64'(fdbad), 64'd0);
    check({tag, "_busy_tail"}, 64'(tail), 64'd3);
  endtask

  initial begin
    int n, base;
    repeat (3) @(negedge clk);
    check("reset_outputs", {7'd0, all_out()}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {7'd0, all_out()}, 64'd0);

    // Basic single frame
    continuous = 1'b0;
    push_frame(4, 2);
    do_start(4, 2, 2, 3, "accept_basic");
    frame_checks("basic");
    check("snap_taps", {40'd0, snap_d}, 64'h07_08_09);
    check("snap_px", {36'd0, snap_px}, 64'h009C970);
    check("basic_drained", 64'(exp_q.size()), 64'd0);

    // Zero geometry is rejected
    line_taps = 12'd0; lines = 12'd2;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("zero_taps", {7'd0, all_out()}, 64'd0);
    line_taps = 12'd4; lines = 12'd0;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("zero_lines", {7'd0, all_out()}, 64'd0);

    // Continuous, h_blank=0 acts as 1: period 1+2*(3+1)+2 = 11
    base = fd_seen;
    fd_stamp.delete();
    repeat (3) push_frame(3, 2);
    continuous = 1'b1;
    do_start(3, 2, 0, 2, "accept_cont");
    n = 0;
    while (fd_seen < base + 3 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    continuous = 1'b0;
    check("cont_bound", {63'd0, n < 300}, 64'd1);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check("cont_frames", 64'(fd_seen - base), 64'd3);
    if (fd_stamp.size() >= 3) begin
      check("cont_period1", 64'(fd_stamp[1] - fd_stamp[0]), 64'd11);
      check("cont_period2", 64'(fd_stamp[2] - fd_stamp[1]), 64'd11);
    end else begin
      check("cont_stamps", 64'(fd_stamp.size()), 64'd3);
    end
    check("cont_drained", 64'(exp_q.size()), 64'd0);

    // Reset during ACTIVE
    push_frame(4, 2);
    do_start(4, 2, 2, 3, "accept_pre_rst");
    n = 0;
    while (!lval && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check("pre_rst_active", {63'd0, lval}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {7'd0, all_out()}, 64'd0);
    exp_q.delete();
    frame_no = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_resume", {7'd0, all_out()}, 64'd0);
    push_frame(4, 2);
    do_start(4, 2, 2, 3, "accept_post_rst");
    frame_checks("post_rst");
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
